// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, ROM address, instruction register with valid/ready to decode.
// Optional FETCH_PERF_EN adds a saturating stall_cnt output counting decode back-pressure cycles.
module fetch_unit #(
  parameter logic [7:0] RESET_PC    = 8'h00,
  parameter logic [4:0] STOP_OPCODE = 5'b10111
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [7:0]  rom_addr,
  input  logic [15:0] rom_data,
  output logic [15:0] ir,
  output logic [7:0]  ir_pc,
  output logic        ir_valid,
  input  logic        ir_ready,
  input  logic        redirect,
  input  logic [7:0]  redirect_addr,
  output logic        halted
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0] stall_cnt
`endif
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t     state;
  logic [7:0] pc;
  logic       load;
  logic       accept;

  assign rom_addr = pc;
  assign accept   = ir_valid && ir_ready;
  assign load     = (state == RUN) && (!ir_valid || ir_ready) && !redirect;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      pc       <= RESET_PC;
      ir       <= '0;
      ir_pc    <= '0;
      ir_valid <= 1'b0;
      halted   <= 1'b0;
    end else begin
      unique case (state)
        RUN, DRAIN: begin
          // Redirect outranks both a fetch and the DRAIN->HALT step; the in-flight word is dropped.
          if (redirect) begin
            pc       <= redirect_addr;
            ir_valid <= 1'b0;
            state    <= RUN;
          end else if (load) begin
            ir       <= rom_data;
            ir_pc    <= pc;
            ir_valid <= 1'b1;
            pc       <= pc + 8'd1;
            if (rom_data[15:11] == STOP_OPCODE) state <= DRAIN;
          end else if (accept) begin
            ir_valid <= 1'b0;
            if (state == DRAIN) begin
              state  <= HALT;
              halted <= 1'b1;
            end
          end
        end
        HALT: begin
          ir_valid <= 1'b0;
          halted   <= 1'b1;
        end
        default: state <= RUN;
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (ir_valid && !ir_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule
